// File: rtl/pifan_spi_pkg.sv
// Shared definitions for the fan-controller SPI register bridge: FSM states,
// command byte layout and the register address map.
package pifan_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RFETCH,
    ST_RLOAD,
    ST_RWAIT,
    ST_ABORT
  } state_t;

  localparam int CMD_RD_BIT = 7;

  localparam int REG_PWM_DUTY = 'h00;
  localparam int REG_PWM_FREQ = 'h01;
  localparam int REG_TACH_LO  = 'h02;
  localparam int REG_TACH_HI  = 'h03;
  localparam int REG_CONFIG   = 'h04;
  localparam int REG_STATUS   = 'h05;

  function automatic logic isReadCmd(input logic [7:0] cmd);
    return cmd[CMD_RD_BIT];
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-side (SPI slave) and register-bus signals of the SPI register bridge.
// The bridge uses the slave modport; the environment uses master.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              iRxReady;
  logic [7:0]        iRx;
  logic              iSPICS;
  logic              oTxReady;
  logic [7:0]        oTx;
  logic [ADDR_W-1:0] oRegAddr;
  logic              oRegWr;
  logic [7:0]        oRegWdata;
  logic              oRegRd;
  logic [7:0]        iRegRdata;
  logic              oBusy;
  logic              oFrameErr;

  modport slave (
    input  iRxReady, iRx, iSPICS, iRegRdata,
    output oTxReady, oTx, oRegAddr, oRegWr, oRegWdata, oRegRd, oBusy, oFrameErr
  );

  modport master (
    output iRxReady, iRx, iSPICS, iRegRdata,
    input  oTxReady, oTx, oRegAddr, oRegWr, oRegWdata, oRegRd, oBusy, oFrameErr
  );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop level synchronizer into sysclk; the reset value is a port so
// active-low pins (CS) can start in their inactive state.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic sysclk,
  input  logic iReset,
  input  logic iResetVal,
  input  logic iD,
  output logic oQ
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge sysclk) begin
    if (iReset) pipe <= {STAGES{iResetVal}};
    else        pipe <= {pipe[STAGES-2:0], iD};
  end

  assign oQ = pipe[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns SPI slave bytes into register-bus writes/reads: one command byte,
// then one auto-incrementing register access per following byte.
module spi_reg_ctrl
  import pifan_spi_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic           sysclk,
  input  logic           iReset,
  spi_reg_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state, stateNext;
  logic              rxSync, rxPrev, byteEv, csHigh;
  logic [ADDR_W-1:0] addr, addrNext;
  logic [CNT_W-1:0]  tmoCnt, tmoCntNext;
  logic              timeoutHit, counting;
  logic              txReadyNext, wrNext, errNext, regRd;
  logic [7:0]        txNext, wdataNext;

  spi_sync #(.STAGES(SYNC_STAGES)) uRxSync (
    .sysclk(sysclk), .iReset(iReset), .iResetVal(1'b0), .iD(bus.iRxReady), .oQ(rxSync)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) uCsSync (
    .sysclk(sysclk), .iReset(iReset), .iResetVal(1'b1), .iD(bus.iSPICS), .oQ(csHigh)
  );

  // iRx is stable for several SPI clocks around the ready edge, so it is
  // sampled unsynchronized on the byteEv cycle.
  assign byteEv     = rxSync & ~rxPrev;
  assign counting   = state inside {ST_CMD, ST_WDATA, ST_RWAIT};
  assign timeoutHit = (tmoCnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    stateNext   = state;
    addrNext    = addr;
    tmoCntNext  = tmoCnt;
    txReadyNext = bus.oTxReady;
    txNext      = bus.oTx;
    wrNext      = 1'b0;
    wdataNext   = bus.oRegWdata;
    errNext     = 1'b0;
    regRd       = 1'b0;

    if (state == ST_IDLE || byteEv) tmoCntNext = '0;
    else if (counting)              tmoCntNext = tmoCnt + 1'b1;

    // The write strobe is registered, so the address steps after it is seen.
    if (bus.oRegWr) addrNext = addr + 1'b1;

    if (state != ST_IDLE && csHigh) begin
      stateNext   = ST_IDLE;
      txReadyNext = 1'b0;
    end

    unique case (state)
      ST_IDLE: if (!csHigh) stateNext = ST_CMD;
      ST_CMD: if (!csHigh) begin
        if (byteEv) begin
          addrNext  = bus.iRx[ADDR_W-1:0];
          stateNext = isReadCmd(bus.iRx) ? ST_RFETCH : ST_WDATA;
        end else if (timeoutHit) begin
          errNext   = 1'b1;
          stateNext = ST_ABORT;
        end
      end
      ST_WDATA: begin
        if (byteEv) begin
          wrNext    = 1'b1;
          wdataNext = bus.iRx;
        end else if (!csHigh && timeoutHit) begin
          errNext   = 1'b1;
          stateNext = ST_ABORT;
        end
      end
      ST_RFETCH: if (!csHigh) begin
        if (byteEv) begin
          errNext   = 1'b1;
          stateNext = ST_ABORT;
        end else begin
          regRd     = 1'b1;
          stateNext = ST_RLOAD;
        end
      end
      ST_RLOAD: if (!csHigh) begin
        if (byteEv) begin
          errNext     = 1'b1;
          txReadyNext = 1'b0;
          stateNext   = ST_ABORT;
        end else begin
          txNext      = bus.iRegRdata;
          txReadyNext = 1'b1;
          stateNext   = ST_RWAIT;
        end
      end
      ST_RWAIT: if (!csHigh) begin
        if (byteEv) begin
          txReadyNext = 1'b0;
          addrNext    = addr + 1'b1;
          stateNext   = ST_RFETCH;
        end else if (timeoutHit) begin
          errNext     = 1'b1;
          txReadyNext = 1'b0;
          stateNext   = ST_ABORT;
        end
      end
      ST_ABORT: txReadyNext = 1'b0;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge sysclk) begin
    if (iReset) begin
      state         <= ST_IDLE;
      rxPrev        <= 1'b0;
      addr          <= '0;
      tmoCnt        <= '0;
      bus.oTxReady  <= 1'b0;
      bus.oTx       <= '0;
      bus.oRegWr    <= 1'b0;
      bus.oRegWdata <= '0;
      bus.oFrameErr <= 1'b0;
    end else begin
      state         <= stateNext;
      rxPrev        <= rxSync;
      addr          <= addrNext;
      tmoCnt        <= tmoCntNext;
      bus.oTxReady  <= txReadyNext;
      bus.oTx       <= txNext;
      bus.oRegWr    <= wrNext;
      bus.oRegWdata <= wdataNext;
      bus.oFrameErr <= errNext;
    end
  end

  assign bus.oRegAddr = addr;
  assign bus.oRegRd   = regRd;
  assign bus.oBusy    = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frames plus random frames
// checked against a byte-level model of the command/auto-increment protocol.
module tb_spi_reg_ctrl;
  import pifan_spi_pkg::*;

  localparam int ADDR_W = 7;
  localparam int SYNC   = 2;
  localparam int TMO    = 100;
  localparam int HOLD   = 12;
  localparam int GAP    = 12;

  logic sysclk = 1'b0;
  logic iReset;
  always #5 sysclk = ~sysclk;

  spi_reg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .sysclk(sysclk),
    .iReset(iReset),
    .bus(bus)
  );

  logic [7:0] refMem [128];
  logic [7:0] fd [4];
  int errors = 0;
  int checks = 0;
  int frameErrs = 0;
  int overlaps = 0;
  int wrObs[$];
  int rdObs[$];
  int txObs[$];
  logic txPrev = 1'b0;

  // Register bank: data is valid only in the cycle after the read strobe.
  always @(posedge sysclk) bus.iRegRdata <= bus.oRegRd ? refMem[bus.oRegAddr] : 8'hEE;

  always @(negedge sysclk) begin
    if (bus.oRegWr) wrObs.push_back(int'({bus.oRegAddr, bus.oRegWdata}));
    if (bus.oRegRd) rdObs.push_back(int'(bus.oRegAddr));
    if (bus.oRegWr && bus.oRegRd) overlaps++;
    if (bus.oFrameErr) frameErrs++;
    if (bus.oTxReady && !txPrev) txObs.push_back(int'(bus.oTx));
    txPrev = bus.oTxReady;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.iRx = b;
    bus.iRxReady = 1'b1;
    repeat (HOLD) tick();
    bus.iRxReady = 1'b0;
    repeat (GAP) tick();
  endtask

  task automatic csLow();
    bus.iSPICS = 1'b0;
    repeat (4) tick();
  endtask

  task automatic csRelease();
    bus.iSPICS = 1'b1;
    repeat (SYNC + 3) tick();
  endtask

  function automatic int wrWord(input int a, input int d);
    return ((a % 128) << 8) | (d & 'hFF);
  endfunction

  // One complete frame with n data/dummy bytes from fd[]; expectations come
  // from the protocol: writes land at a, a+1, ...; reads prefetch a..a+n.
  task automatic runFrame(input string tag, input bit isRead, input int a, input int n);
    int wb = wrObs.size();
    int rb = rdObs.size();
    int tb = txObs.size();
    int eb = frameErrs;
    int expWr[$];
    int expTx[$];
    logic [7:0] cmd;
    cmd = {isRead, 7'(a)};
    if (isRead) begin
      for (int i = 0; i <= n; i++) expTx.push_back(int'(refMem[(a + i) % 128]));
    end else begin
      for (int i = 0; i < n; i++) begin
        expWr.push_back(wrWord(a + i, fd[i]));
        refMem[(a + i) % 128] = fd[i];
      end
    end
    csLow();
    sendByte(cmd);
    for (int i = 0; i < n; i++) sendByte(fd[i]);
    csRelease();
    check({tag, "_nwr"}, wrObs.size() - wb, expWr.size());
    for (int i = 0; i < expWr.size() && wb + i < wrObs.size(); i++)
      check({tag, "_wr"}, wrObs[wb + i], expWr[i]);
    check({tag, "_ntx"}, txObs.size() - tb, expTx.size());
    for (int i = 0; i < expTx.size() && tb + i < txObs.size(); i++)
      check({tag, "_tx"}, txObs[tb + i], expTx[i]);
    if (isRead) check({tag, "_nrd"}, rdObs.size() - rb, n + 1);
    else        check({tag, "_nrd"}, rdObs.size() - rb, 0);
    check({tag, "_err"}, frameErrs - eb, 0);
    check({tag, "_idle"}, bus.oBusy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, wb, rb, eb;
    for (int i = 0; i < 128; i++) refMem[i] = 8'($urandom);
    iReset = 1'b1;
    bus.iSPICS = 1'b1;
    bus.iRxReady = 1'b0;
    bus.iRx = 8'h00;
    repeat (3) tick();
    check("rst_outs", int'({bus.oTxReady, bus.oTx, bus.oRegAddr, bus.oRegWr, bus.oRegWdata,
                            bus.oRegRd, bus.oBusy, bus.oFrameErr}), 0);
    iReset = 1'b0;
    tick();
    check("rst_idle", bus.oBusy, 0);

    // Write frame 0x05, 0xAA, 0x55
    fd[0] = 8'hAA; fd[1] = 8'h55;
    runFrame("t1", 1'b0, 5, 2);

    // Read frame 0x83 with latency measurement from the byte edge
    refMem[3] = 8'h3C; refMem[4] = 8'hC3;
    rb = rdObs.size();
    csLow();
    bus.iRx = 8'h83;
    bus.iRxReady = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!bus.oTxReady && lat < 30);
    check("t2_latency", lat, SYNC + 3);
    check("t2_tx0", bus.oTx, 'h3C);
    check("t2_rdaddr0", rdObs.size() > rb ? rdObs[rb] : -1, 3);
    repeat (HOLD - lat) tick();
    bus.iRxReady = 1'b0;
    repeat (GAP) tick();
    sendByte(8'($urandom));
    check("t2_txrdy1", bus.oTxReady, 1);
    check("t2_tx1", bus.oTx, 'hC3);
    check("t2_rdaddr1", rdObs.size() > rb + 1 ? rdObs[rb + 1] : -1, 4);
    csRelease();
    check("t2_txrdy_end", bus.oTxReady, 0);

    // Address wrap
    fd[0] = 8'h12; fd[1] = 8'h34;
    runFrame("t3", 1'b0, 'h7F, 2);

    // CS rises after the command byte only
    wb = wrObs.size(); rb = rdObs.size();
    csLow();
    sendByte(8'h10);
    bus.iSPICS = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (bus.oBusy && lat < 30);
    check("t4_idle_lat", lat, SYNC + 1);
    repeat (4) tick();
    check("t4_nostrobe", (wrObs.size() - wb) + (rdObs.size() - rb), 0);

    // Data byte and CS rise in the same cycle: the write still happens
    wb = wrObs.size();
    csLow();
    sendByte(8'h20);
    bus.iRx = 8'h5A;
    bus.iRxReady = 1'b1;
    bus.iSPICS = 1'b1;
    repeat (HOLD) tick();
    bus.iRxReady = 1'b0;
    repeat (GAP) tick();
    refMem['h20] = 8'h5A;
    check("t4_samecyc_n", wrObs.size() - wb, 1);
    check("t4_samecyc_wr", wrObs.size() > wb ? wrObs[wb] : -1, wrWord('h20, 'h5A));
    check("t4_samecyc_idle", bus.oBusy, 0);

    // Timeout after the command byte
    wb = wrObs.size(); rb = rdObs.size(); eb = frameErrs;
    csLow();
    bus.iRx = 8'h30;
    bus.iRxReady = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!bus.oFrameErr && lat < 300);
    check("t5_tmo_lat", lat, SYNC + TMO + 1);
    tick();
    check("t5_pulse_w", bus.oFrameErr, 0);
    bus.iRxReady = 1'b0;
    repeat (GAP) tick();
    sendByte(8'h66);
    sendByte(8'h77);
    check("t5_nostrobe", (wrObs.size() - wb) + (rdObs.size() - rb), 0);
    check("t5_nerr", frameErrs - eb, 1);
    check("t5_abort_busy", bus.oBusy, 1);
    csRelease();
    check("t5_idle", bus.oBusy, 0);

    // Reset while waiting in RWAIT, then a fresh frame with CS still low
    csLow();
    sendByte(8'h85);
    check("t6_rwait_rdy", bus.oTxReady, 1);
    iReset = 1'b1;
    tick();
    check("t6_rst_outs", int'({bus.oTxReady, bus.oTx, bus.oRegAddr, bus.oRegWr, bus.oRegWdata,
                               bus.oRegRd, bus.oBusy, bus.oFrameErr}), 0);
    iReset = 1'b0;
    wb = wrObs.size();
    repeat (4) tick();
    sendByte(8'h02);
    sendByte(8'h11);
    refMem[2] = 8'h11;
    csRelease();
    check("t6_n", wrObs.size() - wb, 1);
    check("t6_wr", wrObs.size() > wb ? wrObs[wb] : -1, wrWord(2, 'h11));

    // Random frames
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 4; i++) fd[i] = 8'($urandom);
      runFrame($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 127)), int'($urandom_range(1, 4)));
    end

    check("no_overlap", overlaps, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
